level_checker_p: RTL and testbench

- Parametrised successor to the monitor's single-shot level checker.
- Compares each ADC conversion against per-channel soft/hard high/low thresholds held in an external synchronous threshold RAM. Generalises ADC width and channel count.
- Adds per-channel debounce: N consecutive violating samples are needed before a violation is flagged.
- Adds an overrun counter for strobes dropped while busy. Sits between the ADC sequencer and the power-control/crash logic, and is a wishbone slave.

---
 rtl/level_checker_p.sv | 257 +++++++++++++++++++++++++
 tb/tb_level_checker_p.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/level_checker_p.sv
// level_checker_p
// Checks each ADC conversion against per-channel soft/hard low/high limits
// held in an external synchronous threshold RAM. Requires a programmable run
// of consecutive violating samples per channel before it flags a violation.
// Captures the source and value of the first soft/hard violation, with a lock
// that a source read releases. Counts crashes and strobes dropped while busy.
// Ports:
//   wb_*          wishbone slave: RAM window below 4*NUM_CHAN, registers at 16'h0100+
//   adc_*         conversion strobe, channel and result from the ADC sequencer
//   soft_reset    drops soft_thresh_valid and the soft lock
//   soft_en/hard_en   enable capture of soft/hard violations
//   soft_viol/hard_viol   one-cycle violation pulses
//   v_in_range    per-channel hard in-range status
//   ram_*         threshold RAM port, address = {type, channel, pol}
//
// state | meaning
// IDLE  | waiting for adc_strb
// CHECK | four RAM compares: soft-low, soft-high, hard-low, hard-high
// SEND  | debounce update, pulses, status and capture
module level_checker_p #(
  parameter int NUM_CHAN    = 32,
  parameter int CHAN_W      = 5,
  parameter int ADC_W       = 12,
  parameter int DEB_W       = 4,
  parameter int DEB_DEFAULT = 1
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [15:0]         wb_adr_i,
  input  logic [15:0]         wb_dat_i,
  output logic [15:0]         wb_dat_o,
  output logic                wb_ack_o,
  input  logic                adc_strb,
  input  logic [CHAN_W-1:0]   adc_channel,
  input  logic [ADC_W-1:0]    adc_result,
  input  logic                soft_reset,
  input  logic                soft_en,
  input  logic                hard_en,
  output logic                soft_viol,
  output logic                hard_viol,
  output logic [NUM_CHAN-1:0] v_in_range,
  output logic [CHAN_W+1:0]   ram_raddr,
  output logic [CHAN_W+1:0]   ram_waddr,
  input  logic [ADC_W-1:0]    ram_rdata,
  output logic [ADC_W-1:0]    ram_wdata,
  output logic                ram_wen
);

  localparam int AW = CHAN_W + 2;
  localparam logic [15:0]      RAM_LIM    = 16'(4 * NUM_CHAN);
  localparam logic [CHAN_W:0]  NUM_CHAN_L = (CHAN_W + 1)'(NUM_CHAN);
  localparam logic [DEB_W-1:0] DEB_MAX    = '1;

  typedef enum logic [1:0] {IDLE, CHECK, SEND} state_t;

  state_t              state_q;
  logic                ack_q, rd_ram_q;
  logic [AW-1:0]       rd_addr_q;
  logic [15:0]         reg_rdata_q, reg_rd;
  logic [ADC_W-1:0]    res_q;
  logic [CHAN_W-1:0]   ch_q;
  logic [1:0]          ctype_q;
  logic                wait_q, soft_bad_q, hard_bad_q;
  logic                soft_valid_q, hard_valid_q, soft_lock_q, hard_lock_q;
  logic [CHAN_W-1:0]   soft_src_q, hard_src_q;
  logic [ADC_W-1:0]    soft_val_q, hard_val_q;
  logic [15:0]         crash_q, ovr_q;
  logic [DEB_W-1:0]    deb_q;
  logic [DEB_W-1:0]    soft_cnt_q [NUM_CHAN];
  logic [DEB_W-1:0]    hard_cnt_q [NUM_CHAN];
  logic [DEB_W-1:0]    soft_cnt_d, hard_cnt_d;
  logic                soft_flag, hard_flag;
  logic                soft_viol_q, hard_viol_q;
  logic [NUM_CHAN-1:0] v_in_range_q;
  logic [31:0]         vir_pad;

  logic trans, ram_sel, reg_sel, wb_rd_ram, wb_own, cmp_en, cmp_viol, cmp_on;
  logic reg_wr, reg_rd_stb, soft_lock_clr, hard_lock_clr;
  logic dat_unused;

  assign trans     = wb_cyc_i & wb_stb_i & ~ack_q;
  assign ram_sel   = wb_adr_i < RAM_LIM;
  assign reg_sel   = wb_adr_i[15:4] == 12'h010;
  assign wb_rd_ram = trans & ram_sel & ~wb_we_i;
  // RAM read port belongs to the wishbone for the trans and the ack cycle
  assign wb_own    = wb_rd_ram | (ack_q & rd_ram_q);
  assign reg_wr    = trans & wb_we_i & reg_sel;
  assign reg_rd_stb = trans & ~wb_we_i & reg_sel;

  assign ram_raddr = wb_rd_ram ? wb_adr_i[AW-1:0] :
                     (ack_q & rd_ram_q) ? rd_addr_q : {ctype_q[1], ch_q, ctype_q[0]};
  assign ram_waddr = wb_adr_i[AW-1:0];
  assign ram_wdata = wb_dat_i[ADC_W-1:0];
  assign ram_wen   = trans & wb_we_i & ram_sel;
  assign wb_ack_o  = ack_q;
  assign wb_dat_o  = !ack_q ? 16'h0 : rd_ram_q ? 16'(ram_rdata) : reg_rdata_q;
  assign dat_unused = ^wb_dat_i;

  assign soft_viol  = soft_viol_q;
  assign hard_viol  = hard_viol_q;
  assign v_in_range = v_in_range_q;
  assign vir_pad    = 32'(v_in_range_q);

  assign soft_lock_clr = soft_reset | (reg_rd_stb & (wb_adr_i[3:0] == 4'h2));
  assign hard_lock_clr = reg_rd_stb & (wb_adr_i[3:0] == 4'h4);

  // wait_q covers the RAM read latency after the compare address changed
  assign cmp_en   = (state_q == CHECK) & ~wait_q & ~wb_own;
  assign cmp_viol = ctype_q[0] ? (ram_rdata < res_q) : (ram_rdata > res_q);
  assign cmp_on   = ctype_q[1] ? hard_valid_q : soft_valid_q;

  always_comb begin
    soft_cnt_d = '0;
    hard_cnt_d = '0;
    if (soft_bad_q)
      soft_cnt_d = (soft_cnt_q[ch_q] == DEB_MAX) ? DEB_MAX : soft_cnt_q[ch_q] + 1'b1;
    if (hard_bad_q)
      hard_cnt_d = (hard_cnt_q[ch_q] == DEB_MAX) ? DEB_MAX : hard_cnt_q[ch_q] + 1'b1;
    soft_flag = soft_cnt_d >= deb_q;
    hard_flag = hard_cnt_d >= deb_q;
  end

  always_comb begin
    reg_rd = '0;
    if (reg_sel) begin
      case (wb_adr_i[3:0])
        4'h0: reg_rd = {15'h0, soft_valid_q};
        4'h1: reg_rd = {15'h0, hard_valid_q};
        4'h2: reg_rd = 16'(soft_src_q);
        4'h3: reg_rd = 16'(soft_val_q);
        4'h4: reg_rd = 16'(hard_src_q);
        4'h5: reg_rd = 16'(hard_val_q);
        4'h6: reg_rd = vir_pad[15:0];
        4'h7: reg_rd = vir_pad[31:16];
        4'h8: reg_rd = crash_q;
        4'h9: reg_rd = 16'(deb_q);
        4'hA: reg_rd = ovr_q;
        default: reg_rd = '0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      ack_q        <= 1'b0;
      rd_ram_q     <= 1'b0;
      rd_addr_q    <= '0;
      reg_rdata_q  <= '0;
      res_q        <= '0;
      ch_q         <= '0;
      ctype_q      <= '0;
      wait_q       <= 1'b0;
      soft_bad_q   <= 1'b0;
      hard_bad_q   <= 1'b0;
      soft_valid_q <= 1'b0;
      hard_valid_q <= 1'b0;
      soft_lock_q  <= 1'b0;
      hard_lock_q  <= 1'b0;
      soft_src_q   <= '0;
      hard_src_q   <= '0;
      soft_val_q   <= '0;
      hard_val_q   <= '0;
      crash_q      <= '0;
      ovr_q        <= '0;
      deb_q        <= DEB_W'(DEB_DEFAULT);
      soft_viol_q  <= 1'b0;
      hard_viol_q  <= 1'b0;
      v_in_range_q <= '0;
      for (int i = 0; i < NUM_CHAN; i++) begin
        soft_cnt_q[i] <= '0;
        hard_cnt_q[i] <= '0;
      end
    end else begin
      ack_q       <= trans;
      rd_ram_q    <= wb_rd_ram;
      soft_viol_q <= 1'b0;
      hard_viol_q <= 1'b0;
      if (trans) begin
        rd_addr_q   <= wb_adr_i[AW-1:0];
        reg_rdata_q <= reg_rd;
      end

      if (adc_strb && state_q != IDLE && ovr_q != 16'hFFFF)
        ovr_q <= ovr_q + 16'd1;

      case (state_q)
        IDLE: begin
          if (adc_strb && ({1'b0, adc_channel} < NUM_CHAN_L)) begin
            res_q      <= adc_result;
            ch_q       <= adc_channel;
            soft_bad_q <= 1'b0;
            hard_bad_q <= 1'b0;
            ctype_q    <= 2'd0;
            wait_q     <= 1'b1;
            state_q    <= CHECK;
          end
        end
        CHECK: begin
          if (cmp_en) begin
            if (cmp_on && cmp_viol) begin
              if (ctype_q[1]) hard_bad_q <= 1'b1;
              else            soft_bad_q <= 1'b1;
            end
            if (ctype_q == 2'd3) begin
              state_q <= SEND;
            end else begin
              ctype_q <= ctype_q + 2'd1;
              wait_q  <= 1'b1;
            end
          end else begin
            wait_q <= wb_own;
          end
        end
        SEND: begin
          soft_cnt_q[ch_q] <= soft_cnt_d;
          hard_cnt_q[ch_q] <= hard_cnt_d;
          soft_viol_q      <= soft_flag;
          hard_viol_q      <= hard_flag;
          if (hard_valid_q) v_in_range_q[ch_q] <= ~hard_flag;
          if (hard_flag && !hard_lock_q && hard_en) begin
            hard_src_q  <= ch_q;
            hard_val_q  <= res_q;
            crash_q     <= crash_q + 16'd1;
            hard_lock_q <= 1'b1;
          end
          if (soft_flag && !soft_lock_q && soft_en) begin
            soft_src_q  <= ch_q;
            soft_val_q  <= res_q;
            soft_lock_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (reg_wr) begin
        case (wb_adr_i[3:0])
          4'h0: soft_valid_q <= wb_dat_i[0];
          4'h1: hard_valid_q <= wb_dat_i[0];
          4'h9: deb_q <= (wb_dat_i[DEB_W-1:0] == '0) ? DEB_W'(1) : wb_dat_i[DEB_W-1:0];
          4'hA: ovr_q <= '0;
          default: ;
        endcase
      end

      // clears come last so they override a same-cycle set or write
      if (soft_reset)    soft_valid_q <= 1'b0;
      if (soft_lock_clr) soft_lock_q  <= 1'b0;
      if (hard_lock_clr) hard_lock_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_level_checker_p.sv
module tb_level_checker_p;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [15:0] adr, dat_w;
  logic [15:0] dat_r;
  logic        ack;
  logic        strb;
  logic [4:0]  chan;
  logic [11:0] result;
  logic        soft_rst, soft_en, hard_en;
  logic        soft_viol, hard_viol;
  logic [31:0] v_in_range;
  logic [6:0]  raddr, waddr;
  logic [11:0] rdata, wdata;
  logic        wen;

  logic [11:0] mem [128];

  int n_asserts = 0;
  int n_fail    = 0;
  int soft_pulses = 0;
  int hard_pulses = 0;
  int sp0, hp0;
  logic [15:0] rv;
  logic        ack_prev = 1'b0;

  always #5 clk = ~clk;

  level_checker_p dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(dat_r), .wb_ack_o(ack),
    .adc_strb(strb), .adc_channel(chan), .adc_result(result),
    .soft_reset(soft_rst), .soft_en(soft_en), .hard_en(hard_en),
    .soft_viol(soft_viol), .hard_viol(hard_viol), .v_in_range(v_in_range),
    .ram_raddr(raddr), .ram_waddr(waddr), .ram_rdata(rdata),
    .ram_wdata(wdata), .ram_wen(wen)
  );

  // external synchronous threshold RAM
  always @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (soft_viol) soft_pulses++;
    if (hard_viol) hard_pulses++;
    if (ack_prev) check_eq("ack_one_cycle", {31'b0, ack}, 0);
    ack_prev = ack;
  end

  // all tasks start and end at a falling edge
  task automatic wait_ack();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ack) break;
    end
  endtask

  task automatic wb_write(input logic [15:0] a, input logic [15:0] d);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_w = d;
    wait_ack();
    check_eq("wb_wr_ack", {31'b0, ack}, 1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input logic [15:0] a, output logic [15:0] d);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
    wait_ack();
    check_eq("wb_rd_ack", {31'b0, ack}, 1);
    d = dat_r;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [15:0] a, input logic [15:0] exp);
    logic [15:0] v;
    wb_read(a, v);
    check_eq(tag, {16'b0, v}, {16'b0, exp});
  endtask

  task automatic adc_send(input logic [4:0] ch, input logic [11:0] r);
    strb = 1'b1; chan = ch; result = r;
    @(negedge clk);
    strb = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [15:0] rd_addrs [6] = '{16'd15, 16'd78, 16'd1, 16'd14, 16'd79, 16'h47};
  logic [15:0] rd_exp   [6] = '{16'hFFF, 16'h300, 16'hFFF, 16'h000, 16'hFFF, 16'h800};
  int          deb_exp  [6] = '{0, 0, 0, 0, 0, 1};
  logic [11:0] deb_res  [6] = '{12'h050, 12'h050, 12'h200, 12'h050, 12'h050, 12'h050};

  initial begin
    rst = 1'b1; cyc = 0; stb = 0; we = 0; adr = 0; dat_w = 0;
    strb = 0; chan = 0; result = 0; soft_rst = 0; soft_en = 1; hard_en = 1;
    run(3);
    rst = 1'b0;
    run(1);

    // reset state
    check_eq("rst_soft_viol", {31'b0, soft_viol}, 0);
    check_eq("rst_hard_viol", {31'b0, hard_viol}, 0);
    check_eq("rst_v_in_range", v_in_range, 0);
    check_eq("rst_ack", {31'b0, ack}, 0);
    check_eq("rst_dat_o", {16'b0, dat_r}, 0);
    rd_check("rst_debounce", 16'h0109, 16'd1);
    rd_check("rst_crash", 16'h0108, 16'd0);
    rd_check("rst_overrun", 16'h010A, 16'd0);

    // thresholds: low limits 0, high limits FFF
    for (int i = 0; i < 128; i++) wb_write(16'(i), (i % 2 == 1) ? 16'hFFF : 16'h000);

    // hard-high violation on channel 3
    wb_write(16'h0101, 16'd1);
    wb_write(16'h0047, 16'h800);
    rd_check("ram_rb_47", 16'h0047, 16'h800);
    hp0 = hard_pulses;
    adc_send(5'd3, 12'h700);
    run(14);
    check_eq("t1_clean_pulse", hard_pulses - hp0, 0);
    rd_check("t1_vir_clean", 16'h0106, 16'h0008);
    adc_send(5'd3, 12'h900);
    run(14);
    check_eq("t1_hard_pulse", hard_pulses - hp0, 1);
    check_eq("t1_vir3", {31'b0, v_in_range[3]}, 0);
    rd_check("t1_vir_reg", 16'h0106, 16'h0000);
    rd_check("t1_hard_val", 16'h0105, 16'h900);
    rd_check("t1_crash", 16'h0108, 16'd1);
    rd_check("t1_hard_src", 16'h0104, 16'd3);

    // debounce of 3 on channel 5 soft-low
    wb_write(16'h0109, 16'd3);
    rd_check("t2_debounce", 16'h0109, 16'd3);
    wb_write(16'h0100, 16'd1);
    wb_write(16'h000A, 16'h100);
    sp0 = soft_pulses;
    for (int i = 0; i < 6; i++) begin
      adc_send(5'd5, deb_res[i]);
      run(14);
      check_eq($sformatf("t2_soft_pulses_%0d", i), soft_pulses - sp0, deb_exp[i]);
    end
    rd_check("t2_soft_val", 16'h0103, 16'h050);
    rd_check("t2_soft_src", 16'h0102, 16'd5);

    // wishbone RAM reads keep the checker stalled
    wb_write(16'h0109, 16'd0);
    rd_check("t3_deb_zero_as_one", 16'h0109, 16'd1);
    wb_write(16'h004E, 16'h300);
    sp0 = soft_pulses; hp0 = hard_pulses;
    adc_send(5'd7, 12'h200);
    for (int i = 0; i < 10; i++) begin
      wb_read(rd_addrs[i % 6], rv);
      check_eq($sformatf("t3_ram_rd_%0d", i), {16'b0, rv}, {16'b0, rd_exp[i % 6]});
    end
    check_eq("t3_stalled", hard_pulses - hp0, 0);
    run(14);
    check_eq("t3_hard_pulse", hard_pulses - hp0, 1);
    check_eq("t3_soft_none", soft_pulses - sp0, 0);
    rd_check("t3_hard_val", 16'h0105, 16'h200);
    rd_check("t3_crash", 16'h0108, 16'd2);

    // hard lock holds the first capture until the source is read
    rd_check("t4_src_clear", 16'h0104, 16'd7);
    hp0 = hard_pulses;
    adc_send(5'd3, 12'h900);
    run(14);
    adc_send(5'd7, 12'h100);
    run(14);
    check_eq("t4_two_pulses", hard_pulses - hp0, 2);
    rd_check("t4_locked_val", 16'h0105, 16'h900);
    rd_check("t4_locked_crash", 16'h0108, 16'd3);
    rd_check("t4_locked_src", 16'h0104, 16'd3);
    adc_send(5'd7, 12'h100);
    run(14);
    rd_check("t4_third_val", 16'h0105, 16'h100);
    rd_check("t4_third_crash", 16'h0108, 16'd4);
    rd_check("t4_third_src", 16'h0104, 16'd7);

    // overrun: five strobes on consecutive cycles
    wb_write(16'h010A, 16'd0);
    strb = 1'b1; chan = 5'd0; result = 12'h400;
    run(5);
    strb = 1'b0;
    run(14);
    rd_check("t5_overrun", 16'h010A, 16'd4);
    wb_write(16'h010A, 16'h1234);
    rd_check("t5_overrun_clr", 16'h010A, 16'd0);
    check_eq("t5_vir0", {31'b0, v_in_range[0]}, 1);

    // asynchronous reset in the middle of CHECK
    wb_write(16'h0109, 16'd5);
    rd_check("t6_debounce", 16'h0109, 16'd5);
    adc_send(5'd0, 12'h400);
    run(2);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_vir_async", v_in_range, 0);
    check_eq("t6_hard_async", {31'b0, hard_viol}, 0);
    check_eq("t6_soft_async", {31'b0, soft_viol}, 0);
    run(2);
    rst = 1'b0;
    run(1);
    rd_check("t6_debounce_def", 16'h0109, 16'd1);
    rd_check("t6_hard_valid", 16'h0101, 16'd0);
    rd_check("t6_soft_valid", 16'h0100, 16'd0);
    rd_check("t6_crash", 16'h0108, 16'd0);
    wb_write(16'h0101, 16'd1);
    hp0 = hard_pulses;
    adc_send(5'd3, 12'h900);
    run(14);
    check_eq("t6_hard_pulse", hard_pulses - hp0, 1);
    rd_check("t6_hard_src", 16'h0104, 16'd3);
    rd_check("t6_crash_after", 16'h0108, 16'd1);
    rd_check("t6_overrun", 16'h010A, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
